// File: rtl/ic_diag_pkg.sv
// Shared types and default sizing for the I-cache diagnostic access controller.
package ic_diag_pkg;

  localparam int unsigned IC_DIAG_ADDR_W     = 13;
  localparam int unsigned IC_DIAG_DATA_W     = 71;
  localparam int unsigned IC_DIAG_WAYS       = 4;
  localparam int unsigned IC_DIAG_WAY_W      = 2;
  localparam int unsigned IC_DIAG_RD_LAT     = 2;
  localparam int unsigned IC_DIAG_STARVE_MAX = 8;
  localparam int unsigned IC_DIAG_LAT_W      = 3;  // holds RD_LAT-1 for RD_LAT up to 7
  localparam int unsigned IC_DIAG_CNT_W      = 8;  // starvation counter width

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ISSUE,
    WAIT,
    DONE
  } ic_diag_state_e;

  // Request layout for the default build.
  typedef struct packed {
    logic                      wr;
    logic                      tag;
    logic [IC_DIAG_ADDR_W-1:0] addr;
    logic [IC_DIAG_WAY_W-1:0]  way;
    logic [IC_DIAG_DATA_W-1:0] wdata;
  } ic_diag_req_t;

  // Binary way-number width; never below one bit so single-way builds elaborate.
  function automatic int unsigned ic_diag_way_w(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/ic_diag_starve_cnt.sv
// Saturating starvation counter: counts blocked cycles up to a limit, never wraps.
module ic_diag_starve_cnt
  import ic_diag_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_inc,
  input  logic                     i_clr,
  input  logic [IC_DIAG_CNT_W-1:0] i_limit,
  output logic [IC_DIAG_CNT_W-1:0] o_cnt,
  output logic                     o_hit
);

  logic [IC_DIAG_CNT_W-1:0] r_cnt;

  // Count up while asked, hold at the limit, clear on request.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_hit = (r_cnt == i_limit);

endmodule

// File: rtl/ic_diag_access_ctl.sv
// Sequences TLU I-cache diagnostic requests onto the shared array port,
// yielding to fetch until the starvation guard forces a diag slot.
module ic_diag_access_ctl
  import ic_diag_pkg::*;
#(
  parameter  int unsigned ADDR_W     = IC_DIAG_ADDR_W,
  parameter  int unsigned DATA_W     = IC_DIAG_DATA_W,
  parameter  int unsigned WAYS       = IC_DIAG_WAYS,
  parameter  int unsigned RD_LAT     = IC_DIAG_RD_LAT,
  parameter  int unsigned STARVE_MAX = IC_DIAG_STARVE_MAX,
  localparam int unsigned WAY_W      = ic_diag_way_w(WAYS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              diag_valid,
  output logic              diag_ready,
  input  logic              diag_wr,
  input  logic              diag_tag,
  input  logic [ADDR_W-1:0] diag_addr,
  input  logic [WAY_W-1:0]  diag_way,
  input  logic [DATA_W-1:0] diag_wdata,
  output logic              diag_done,
  output logic [DATA_W-1:0] diag_rdata,
  input  logic              fetch_req,
  output logic              fetch_stall,
  output logic              ic_dbg_en,
  output logic              ic_dbg_wr,
  output logic              ic_dbg_tag,
  output logic [ADDR_W-1:0] ic_dbg_addr,
  output logic [WAYS-1:0]   ic_dbg_way,
  output logic [DATA_W-1:0] ic_dbg_wdata,
  input  logic [DATA_W-1:0] ic_dbg_rdata
);

  // Same fields as ic_diag_req_t, sized by this instance's parameters.
  typedef struct packed {
    logic              wr;
    logic              tag;
    logic [ADDR_W-1:0] addr;
    logic [WAY_W-1:0]  way;
    logic [DATA_W-1:0] wdata;
  } req_t;

  ic_diag_state_e           r_state;
  ic_diag_state_e           w_next;
  req_t                     r_req;
  logic [IC_DIAG_LAT_W-1:0] r_lat;
  logic                     r_ready;
  logic                     r_done;
  logic [DATA_W-1:0]        r_rdata;
  logic                     r_stall;
  logic                     r_en;
  logic                     r_wr;
  logic                     r_tag;
  logic [ADDR_W-1:0]        r_addr;
  logic [WAYS-1:0]          r_way;
  logic [DATA_W-1:0]        r_wdata;
  logic                     w_inc;
  logic                     w_clr;
  logic                     w_hit;
  logic [IC_DIAG_CNT_W-1:0] w_cnt;
  logic                     w_stall_nxt;
  logic [WAYS-1:0]          w_way_dec;

  ic_diag_starve_cnt u_starve (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_inc),
    .i_clr   (w_clr),
    .i_limit (IC_DIAG_CNT_W'(STARVE_MAX)),
    .o_cnt   (w_cnt),
    .o_hit   (w_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state selection and starvation-counter control.
  always_comb begin
    w_next = r_state;
    w_inc  = 1'b0;
    unique case (r_state)
      IDLE:    if (diag_valid) w_next = PEND;
      PEND: begin
        if (!fetch_req || w_hit) begin
          w_next = ISSUE;
        end else begin
          w_inc = 1'b1;
        end
      end
      ISSUE:   w_next = r_req.wr ? DONE : WAIT;
      WAIT:    if (r_lat == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_clr = (r_state == ISSUE) || (r_state == IDLE);

  // Stall is registered, so it is raised one cycle ahead: on the last blocked
  // PEND cycle (counter about to reach the limit) and for the forced ISSUE.
  assign w_stall_nxt = ((w_next == ISSUE) && fetch_req) ||
                       ((w_next == PEND) && w_inc &&
                        (w_cnt == IC_DIAG_CNT_W'(STARVE_MAX - 1)));

  // One-hot way decode; out-of-range way numbers select no way.
  always_comb begin
    w_way_dec = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      w_way_dec[i] = (32'(r_req.way) == i);
    end
  end

  // Capture the TLU request on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req <= '0;
    end else if ((r_state == IDLE) && diag_valid) begin
      r_req.wr    <= diag_wr;
      r_req.tag   <= diag_tag;
      r_req.addr  <= diag_addr;
      r_req.way   <= diag_way;
      r_req.wdata <= diag_wdata;
    end
  end

  // Registered handshake, stall and array-port outputs plus read-latency tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_rdata <= '0;
      r_stall <= 1'b0;
      r_en    <= 1'b0;
      r_wr    <= 1'b0;
      r_tag   <= 1'b0;
      r_addr  <= '0;
      r_way   <= '0;
      r_wdata <= '0;
      r_lat   <= '0;
    end else begin
      r_ready <= (w_next == IDLE);
      r_done  <= (w_next == DONE);
      r_stall <= w_stall_nxt;
      r_en    <= (w_next == ISSUE);
      if (w_next == ISSUE) begin
        r_wr    <= r_req.wr;
        r_tag   <= r_req.tag;
        r_addr  <= r_req.addr;
        r_way   <= w_way_dec;
        r_wdata <= r_req.wdata;
      end else begin
        r_wr    <= 1'b0;
        r_tag   <= 1'b0;
        r_addr  <= '0;
        r_way   <= '0;
        r_wdata <= '0;
      end
      if (r_state == ISSUE) begin
        r_lat <= IC_DIAG_LAT_W'(RD_LAT - 1);
      end else if ((r_state == WAIT) && (r_lat != '0)) begin
        r_lat <= r_lat - 1'b1;
      end
      // WAIT spans RD_LAT cycles; its last cycle is RD_LAT after ic_dbg_en.
      if ((r_state == WAIT) && (r_lat == '0)) begin
        r_rdata <= ic_dbg_rdata;
      end
    end
  end

  assign diag_ready   = r_ready;
  assign diag_done    = r_done;
  assign diag_rdata   = r_rdata;
  assign fetch_stall  = r_stall;
  assign ic_dbg_en    = r_en;
  assign ic_dbg_wr    = r_wr;
  assign ic_dbg_tag   = r_tag;
  assign ic_dbg_addr  = r_addr;
  assign ic_dbg_way   = r_way;
  assign ic_dbg_wdata = r_wdata;

endmodule

// File: tb/tb_ic_diag_access_ctl.sv
// Scoreboard bench for ic_diag_access_ctl with a pipelined I-cache array model.
module tb_ic_diag_access_ctl;

  localparam int unsigned ADDR_W     = 13;
  localparam int unsigned DATA_W     = 71;
  localparam int unsigned WAYS       = 4;
  localparam int unsigned RD_LAT     = 2;
  localparam int unsigned STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              diag_valid = 1'b0;
  logic              diag_ready;
  logic              diag_wr = 1'b0;
  logic              diag_tag = 1'b0;
  logic [ADDR_W-1:0] diag_addr = '0;
  logic [1:0]        diag_way = '0;
  logic [DATA_W-1:0] diag_wdata = '0;
  logic              diag_done;
  logic [DATA_W-1:0] diag_rdata;
  logic              fetch_req = 1'b0;
  logic              fetch_stall;
  logic              ic_dbg_en;
  logic              ic_dbg_wr;
  logic              ic_dbg_tag;
  logic [ADDR_W-1:0] ic_dbg_addr;
  logic [WAYS-1:0]   ic_dbg_way;
  logic [DATA_W-1:0] ic_dbg_wdata;
  logic [DATA_W-1:0] ic_dbg_rdata;

  ic_diag_access_ctl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .WAYS       (WAYS),
    .RD_LAT     (RD_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .diag_valid   (diag_valid),
    .diag_ready   (diag_ready),
    .diag_wr      (diag_wr),
    .diag_tag     (diag_tag),
    .diag_addr    (diag_addr),
    .diag_way     (diag_way),
    .diag_wdata   (diag_wdata),
    .diag_done    (diag_done),
    .diag_rdata   (diag_rdata),
    .fetch_req    (fetch_req),
    .fetch_stall  (fetch_stall),
    .ic_dbg_en    (ic_dbg_en),
    .ic_dbg_wr    (ic_dbg_wr),
    .ic_dbg_tag   (ic_dbg_tag),
    .ic_dbg_addr  (ic_dbg_addr),
    .ic_dbg_way   (ic_dbg_way),
    .ic_dbg_wdata (ic_dbg_wdata),
    .ic_dbg_rdata (ic_dbg_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned n_stall = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Array word content as a function of the access, so a mis-timed sample differs.
  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a,
                                                input logic [WAYS-1:0] w, input logic t);
    return {6'h2B, t, w, a, 16'hA5C3 ^ 16'(a), 31'h1234567 ^ 31'(a)};
  endfunction

  // Array model: read data appears RD_LAT cycles after the strobe cycle, junk otherwise.
  logic [18:0] pipe [RD_LAT] = '{default: '0};
  logic [18:0] pipe_last;
  always @(posedge clk) begin
    pipe[0] <= {ic_dbg_en & ~ic_dbg_wr, ic_dbg_tag, ic_dbg_way, ic_dbg_addr};
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pipe_last    = pipe[RD_LAT-1];
  assign ic_dbg_rdata = pipe_last[18] ? rd_word(pipe_last[12:0], pipe_last[16:13], pipe_last[17])
                                      : '1;

  typedef struct packed {
    logic [89:0] f;
    logic [31:0] c;
  } iss_t;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [31:0]       c;
  } done_t;

  iss_t  q_iss  [$];
  done_t q_done [$];
  logic [DATA_W-1:0] exp_held = '0;

  // Output monitor: pops scoreboard entries as the DUT strobes the array or completes.
  always @(negedge clk) begin
    iss_t  ei;
    done_t ed;
    if (!rst) begin
      if (ic_dbg_en) begin
        if (q_iss.size() == 0) begin
          check_eq("en_unexpected", 1, 0);
        end else begin
          ei = q_iss.pop_front();
          check_eq("en_cycle", cyc, ei.c);
          check_eq("en_fields", {ic_dbg_wr, ic_dbg_tag, ic_dbg_addr, ic_dbg_way,
                                 ic_dbg_wr ? ic_dbg_wdata : 71'h0}, ei.f);
        end
      end
      if (diag_done) begin
        if (q_done.size() == 0) begin
          check_eq("done_unexpected", 1, 0);
        end else begin
          ed = q_done.pop_front();
          check_eq("done_cycle", cyc, ed.c);
          check_eq("done_rdata", diag_rdata, ed.d);
        end
      end
      if (fetch_stall) n_stall++;
    end
  end

  // Present one request, hold it until accepted, and push its expected outcomes.
  task automatic send(input logic wr, input logic tag, input logic [ADDR_W-1:0] addr,
                      input logic [1:0] way, input logic [DATA_W-1:0] wdata,
                      input int unsigned extra, output int unsigned acc);
    int unsigned n = 0;
    logic [WAYS-1:0] oh;
    iss_t  ei;
    done_t ed;
    diag_valid = 1'b1;
    diag_wr    = wr;
    diag_tag   = tag;
    diag_addr  = addr;
    diag_way   = way;
    diag_wdata = wdata;
    while (!diag_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!diag_ready) begin
      check_eq("accept_timeout", 0, 1);
      diag_valid = 1'b0;
      return;
    end
    oh   = 4'b0001 << way;
    ei.f = {wr, tag, addr, oh, wr ? wdata : 71'h0};
    ei.c = acc + 2 + extra;
    q_iss.push_back(ei);
    if (!wr) exp_held = rd_word(addr, oh, tag);
    ed.d = exp_held;
    ed.c = wr ? (acc + 3 + extra) : (acc + 3 + RD_LAT + extra);
    q_done.push_back(ed);
    @(negedge clk);
    diag_valid = 1'b0;
    diag_wr    = 1'b0;
    diag_tag   = 1'b0;
    diag_addr  = '0;
    diag_way   = '0;
    diag_wdata = '0;
  endtask

  task automatic wait_quiet();
    int unsigned n = 0;
    while ((q_iss.size() != 0 || q_done.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q_iss.size() != 0 || q_done.size() != 0) begin
      check_eq("quiet_timeout", q_iss.size() + q_done.size(), 0);
      q_iss.delete();
      q_done.delete();
    end
  endtask

  initial begin
    int unsigned acc;
    int unsigned acc2;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", diag_ready, 1);
    check_eq("rst_done", diag_done, 0);
    check_eq("rst_rdata", diag_rdata, 0);
    check_eq("rst_stall", fetch_stall, 0);
    check_eq("rst_en", ic_dbg_en, 0);
    check_eq("rst_dbg", {ic_dbg_wr, ic_dbg_tag, ic_dbg_addr, ic_dbg_way, ic_dbg_wdata}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reads with fetch idle, across every way and the address extremes.
    send(1'b0, 1'b0, 13'h1A5, 2'd2, '0, 0, acc);
    wait_quiet();
    for (int w = 0; w < 4; w++) begin
      send(1'b0, w[0], 13'($urandom_range(0, 8191)), 2'(w), '0, 0, acc);
      wait_quiet();
    end
    send(1'b0, 1'b1, 13'h1FFF, 2'd3, '0, 0, acc);
    wait_quiet();
    send(1'b0, 1'b0, 13'h0000, 2'd0, '0, 0, acc);
    wait_quiet();

    // Tag write leaves the last read data in place.
    send(1'b1, 1'b1, 13'h0042, 2'd1, 71'h5A, 0, acc);
    wait_quiet();
    repeat (2) @(negedge clk);
    check_eq("rdata_hold", diag_rdata, exp_held);

    // Fetch blocks two PEND cycles then drops: no forced stall.
    n_stall = 0;
    fetch_req = 1'b1;
    send(1'b0, 1'b0, 13'h0777, 2'd0, '0, 2, acc);
    @(negedge clk);
    @(negedge clk);
    fetch_req = 1'b0;
    wait_quiet();
    check_eq("stall_toggle", n_stall, 0);

    // Fetch held busy: starvation guard forces the slot after STARVE_MAX blocked cycles.
    n_stall = 0;
    fetch_req = 1'b1;
    send(1'b0, 1'b1, 13'h0ABC, 2'd3, '0, STARVE_MAX, acc);
    wait_quiet();
    check_eq("stall_starve", n_stall, 2);
    n_stall = 0;
    send(1'b1, 1'b0, 13'h0123, 2'd2, 71'h7_0000_0000_0000_BEEF, STARVE_MAX, acc);
    wait_quiet();
    fetch_req = 1'b0;
    check_eq("stall_starve_wr", n_stall, 2);

    // Back-to-back reads: second request held valid across the first.
    send(1'b0, 1'b0, 13'h0100, 2'd1, '0, 0, acc);
    send(1'b0, 1'b0, 13'h0101, 2'd2, '0, 0, acc2);
    check_eq("b2b_accept", acc2, acc + RD_LAT + 4);
    wait_quiet();

    // Reset during WAIT aborts without a completion pulse.
    send(1'b0, 1'b1, 13'h0555, 2'd0, '0, 0, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_ready", diag_ready, 1);
    check_eq("abort_en", ic_dbg_en, 0);
    check_eq("abort_done", diag_done, 0);
    check_eq("abort_rdata", diag_rdata, 0);
    q_iss.delete();
    q_done.delete();
    exp_held = '0;
    rst = 1'b0;
    repeat (RD_LAT + 3) @(negedge clk);
    send(1'b0, 1'b0, 13'h0F0F, 2'd3, '0, 0, acc);
    wait_quiet();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
